lzss_stream_encoder: RTL and testbench



---
 rtl/lzss_pkg.sv | 38 +++
 rtl/lzss_match_finder.sv | 65 ++++++
 rtl/lzss_stream_encoder.sv | 242 ++++++++++++++++++++++++
 tb/tb_lzss_stream_encoder.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzss_pkg.sv
// Shared types and width helpers for the LZSS stream encoder.
// Used by lzss_stream_encoder and lzss_match_finder.
package lzss_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    MATCH = 2'd1,
    EMIT  = 2'd2,
    SHIFT = 2'd3
  } lzss_state_e;

  localparam logic TOK_LIT = 1'b0;
  localparam logic TOK_REF = 1'b1;

  function automatic int lzss_off_w(input int window_size);
    return (window_size > 1) ? $clog2(window_size) : 1;
  endfunction

  // Clamped to one bit so LOOK_AHEAD_SIZE == MIN_MATCH still yields a legal field.
  function automatic int lzss_len_w(input int look_ahead, input int min_match);
    int span;
    span = look_ahead - min_match + 1;
    return (span > 1) ? $clog2(span) : 1;
  endfunction

  function automatic int lzss_token_w(input int word_size, input int window_size,
                                      input int look_ahead, input int min_match);
    int ref_w;
    ref_w = lzss_off_w(window_size) + lzss_len_w(look_ahead, min_match);
    return 1 + ((word_size > ref_w) ? word_size : ref_w);
  endfunction

  // Width of a counter that must hold the value n itself.
  function automatic int lzss_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lzss_match_finder.sv
// Combinational comparator array: for every distance, the length of the prefix of the
// look-ahead that matches the window, then the longest (smallest distance on ties).
module lzss_match_finder
  import lzss_pkg::*;
#(
  parameter int WORD_SIZE       = 8,
  parameter int WINDOW_SIZE     = 32,
  parameter int LOOK_AHEAD_SIZE = 4,
  parameter int DIST_W          = 6,
  parameter int LCNT_W          = 3
) (
  input  logic [WINDOW_SIZE*WORD_SIZE-1:0]     win_flat,
  input  logic [LOOK_AHEAD_SIZE*WORD_SIZE-1:0] la_flat,
  input  logic [DIST_W-1:0]                    win_count,
  input  logic [LCNT_W-1:0]                    la_count,
  output logic [DIST_W-1:0]                    best_dist,
  output logic [LCNT_W-1:0]                    best_len
);

  logic [WINDOW_SIZE*LCNT_W-1:0] cand_flat;

  for (genvar gi = 0; gi < WINDOW_SIZE; gi++) begin : g_dist
    logic [LOOK_AHEAD_SIZE-1:0] hit;
    logic [LCNT_W-1:0]          run_len;
    logic                       run;

    // Element gk is compared with the symbol (gi+1)-gk back; gk > gi would reach into
    // the look-ahead itself, so those positions never match.
    for (genvar gk = 0; gk < LOOK_AHEAD_SIZE; gk++) begin : g_k
      if (gk <= gi) begin : g_cmp
        assign hit[gk] = (la_flat[gk*WORD_SIZE +: WORD_SIZE] ==
                          win_flat[(gi-gk)*WORD_SIZE +: WORD_SIZE]) &&
                         (LCNT_W'(gk) < la_count);
      end else begin : g_none
        assign hit[gk] = 1'b0;
      end
    end

    always_comb begin
      run     = (DIST_W'(gi + 1) <= win_count);
      run_len = '0;
      for (int k = 0; k < LOOK_AHEAD_SIZE; k++) begin
        run = run && hit[k];
        if (run) begin
          run_len = LCNT_W'(k + 1);
        end
      end
    end

    assign cand_flat[gi*LCNT_W +: LCNT_W] = run_len;
  end

  // Strict greater-than keeps the earliest (smallest) distance on equal lengths.
  always_comb begin
    best_len  = '0;
    best_dist = '0;
    for (int d = 0; d < WINDOW_SIZE; d++) begin
      if (cand_flat[d*LCNT_W +: LCNT_W] > best_len) begin
        best_len  = cand_flat[d*LCNT_W +: LCNT_W];
        best_dist = DIST_W'(d + 1);
      end
    end
  end

endmodule

// File: rtl/lzss_stream_encoder.sv
// LZSS stream encoder: valid/ready byte input, literal/reference token output, window
// cleared per stream. Optional statistics counters under `define LZSS_STATS_EN.
module lzss_stream_encoder
  import lzss_pkg::*;
#(
  parameter int WORD_SIZE       = 8,
  parameter int WINDOW_SIZE     = 32,
  parameter int LOOK_AHEAD_SIZE = 4,
  parameter int MIN_MATCH       = 2,
  localparam int TOKEN_W = lzss_token_w(WORD_SIZE, WINDOW_SIZE, LOOK_AHEAD_SIZE, MIN_MATCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef LZSS_STATS_EN
  input  logic                 stat_clr,
  output logic [31:0]          stat_lit_cnt,
  output logic [31:0]          stat_ref_cnt,
  output logic [31:0]          stat_sym_cnt,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TOKEN_W-1:0]   out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int OFF_W    = lzss_off_w(WINDOW_SIZE);
  localparam int LEN_W    = lzss_len_w(LOOK_AHEAD_SIZE, MIN_MATCH);
  localparam int DIST_W   = lzss_cnt_w(WINDOW_SIZE);
  localparam int LCNT_W   = lzss_cnt_w(LOOK_AHEAD_SIZE);
  localparam int LA_IDX_W = $clog2(LOOK_AHEAD_SIZE);

  lzss_state_e          state_q, state_d;
  logic [WORD_SIZE-1:0] la_q  [LOOK_AHEAD_SIZE];
  logic [WORD_SIZE-1:0] la_d  [LOOK_AHEAD_SIZE];
  logic [WORD_SIZE-1:0] win_q [WINDOW_SIZE];
  logic [WORD_SIZE-1:0] win_d [WINDOW_SIZE];
  logic [LCNT_W-1:0]    la_count_q, la_count_d;
  logic [DIST_W-1:0]    win_count_q, win_count_d;
  logic                 drain_q, drain_d;
  logic [DIST_W-1:0]    best_dist_q, best_dist_d;
  logic [LCNT_W-1:0]    best_len_q, best_len_d;
  logic [LCNT_W-1:0]    consume_q, consume_d;
  logic                 end_q, end_d;
  logic                 rdy_en_q;

  logic [WINDOW_SIZE*WORD_SIZE-1:0]     win_flat;
  logic [LOOK_AHEAD_SIZE*WORD_SIZE-1:0] la_flat;
  logic [DIST_W-1:0]                    fd_dist;
  logic [LCNT_W-1:0]                    fd_len;

  logic                 is_ref;
  logic [LCNT_W-1:0]    consume;
  logic [OFF_W-1:0]     ref_dist;
  logic [LEN_W-1:0]     ref_len;
  logic [TOKEN_W-2:0]   payload;
  logic                 in_hs;
  logic                 out_hs;

  for (genvar gi = 0; gi < WINDOW_SIZE; gi++) begin : g_win_flat
    assign win_flat[gi*WORD_SIZE +: WORD_SIZE] = win_q[gi];
  end

  for (genvar gi = 0; gi < LOOK_AHEAD_SIZE; gi++) begin : g_la_flat
    assign la_flat[gi*WORD_SIZE +: WORD_SIZE] = la_q[gi];
  end

  lzss_match_finder #(
    .WORD_SIZE       (WORD_SIZE),
    .WINDOW_SIZE     (WINDOW_SIZE),
    .LOOK_AHEAD_SIZE (LOOK_AHEAD_SIZE),
    .DIST_W          (DIST_W),
    .LCNT_W          (LCNT_W)
  ) u_match_finder (
    .win_flat  (win_flat),
    .la_flat   (la_flat),
    .win_count (win_count_q),
    .la_count  (la_count_q),
    .best_dist (fd_dist),
    .best_len  (fd_len)
  );

  assign is_ref   = (best_len_q >= LCNT_W'(MIN_MATCH));
  assign consume  = is_ref ? best_len_q : LCNT_W'(1);
  assign ref_dist = OFF_W'(best_dist_q - DIST_W'(1));
  assign ref_len  = LEN_W'(best_len_q - LCNT_W'(MIN_MATCH));

  // rdy_en_q holds in_ready low until the first clock after reset release.
  assign in_ready  = rdy_en_q && (state_q == FILL) && !drain_q &&
                     (la_count_q < LCNT_W'(LOOK_AHEAD_SIZE));
  assign out_valid = (state_q == EMIT);
  assign out_last  = out_valid && drain_q && (consume == la_count_q);
  assign busy      = !((state_q == FILL) && (la_count_q == '0));
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  always_comb begin
    payload = '0;
    if (is_ref) begin
      payload[OFF_W+LEN_W-1:LEN_W] = ref_dist;
      payload[LEN_W-1:0]           = ref_len;
    end else begin
      payload[WORD_SIZE-1:0] = la_q[0];
    end
    out_data = out_valid ? {(is_ref ? TOK_REF : TOK_LIT), payload} : '0;
  end

  always_comb begin
    state_d     = state_q;
    la_d        = la_q;
    win_d       = win_q;
    la_count_d  = la_count_q;
    win_count_d = win_count_q;
    drain_d     = drain_q;
    best_dist_d = best_dist_q;
    best_len_d  = best_len_q;
    consume_d   = consume_q;
    end_d       = end_q;
    case (state_q)
      FILL: begin
        if (in_hs) begin
          la_d[la_count_q[LA_IDX_W-1:0]] = in_data;
          la_count_d = la_count_q + LCNT_W'(1);
          if (in_last) begin
            drain_d = 1'b1;
          end
        end
        if ((la_count_d == LCNT_W'(LOOK_AHEAD_SIZE)) || (drain_d && (la_count_d != '0))) begin
          state_d = MATCH;
        end
      end
      MATCH: begin
        best_dist_d = fd_dist;
        best_len_d  = fd_len;
        state_d     = EMIT;
      end
      EMIT: begin
        if (out_hs) begin
          consume_d = consume;
          end_d     = out_last;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        win_d[0] = la_q[0];
        for (int i = 1; i < WINDOW_SIZE; i++) begin
          win_d[i] = win_q[i-1];
        end
        for (int i = 0; i < LOOK_AHEAD_SIZE - 1; i++) begin
          la_d[i] = la_q[i+1];
        end
        la_count_d = la_count_q - LCNT_W'(1);
        if (win_count_q != DIST_W'(WINDOW_SIZE)) begin
          win_count_d = win_count_q + DIST_W'(1);
        end
        consume_d = consume_q - LCNT_W'(1);
        if (consume_q == LCNT_W'(1)) begin
          state_d = FILL;
          // The stream just ended: the next one must not see this history.
          if (end_q) begin
            win_count_d = '0;
            drain_d     = 1'b0;
            end_d       = 1'b0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      la_count_q  <= '0;
      win_count_q <= '0;
      drain_q     <= 1'b0;
      best_dist_q <= '0;
      best_len_q  <= '0;
      consume_q   <= '0;
      end_q       <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      la_count_q  <= la_count_d;
      win_count_q <= win_count_d;
      drain_q     <= drain_d;
      best_dist_q <= best_dist_d;
      best_len_q  <= best_len_d;
      consume_q   <= consume_d;
      end_q       <= end_d;
      rdy_en_q    <= 1'b1;
    end
  end

  // Symbol storage needs no reset: the counters decide what is valid.
  always_ff @(posedge clk) begin
    la_q  <= la_d;
    win_q <= win_d;
  end

`ifdef LZSS_STATS_EN
  logic [31:0] stat_lit_cnt_q, stat_lit_cnt_d;
  logic [31:0] stat_ref_cnt_q, stat_ref_cnt_d;
  logic [31:0] stat_sym_cnt_q, stat_sym_cnt_d;

  always_comb begin
    stat_lit_cnt_d = stat_lit_cnt_q;
    stat_ref_cnt_d = stat_ref_cnt_q;
    stat_sym_cnt_d = stat_sym_cnt_q;
    if (stat_clr) begin
      stat_lit_cnt_d = '0;
      stat_ref_cnt_d = '0;
      stat_sym_cnt_d = '0;
    end else begin
      if (out_hs && !is_ref) stat_lit_cnt_d = stat_lit_cnt_q + 32'd1;
      if (out_hs && is_ref)  stat_ref_cnt_d = stat_ref_cnt_q + 32'd1;
      if (in_hs)             stat_sym_cnt_d = stat_sym_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lit_cnt_q <= '0;
      stat_ref_cnt_q <= '0;
      stat_sym_cnt_q <= '0;
    end else begin
      stat_lit_cnt_q <= stat_lit_cnt_d;
      stat_ref_cnt_q <= stat_ref_cnt_d;
      stat_sym_cnt_q <= stat_sym_cnt_d;
    end
  end

  assign stat_lit_cnt = stat_lit_cnt_q;
  assign stat_ref_cnt = stat_ref_cnt_q;
  assign stat_sym_cnt = stat_sym_cnt_q;
`endif

endmodule

// File: tb/tb_lzss_stream_encoder.sv
// Randomised self-checking bench for lzss_stream_encoder against a greedy LZSS model
// computed directly from the stream contents.
module tb_lzss_stream_encoder;

  localparam int WS = 8;
  localparam int W  = 32;
  localparam int L  = 4;
  localparam int MM = 2;
  localparam int TW = 9;

  typedef struct packed {
    logic          last;
    logic [TW-1:0] data;
  } tok_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WS-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [TW-1:0] out_data;
  logic          out_last;
  logic          busy;
`ifdef LZSS_STATS_EN
  logic          stat_clr = 1'b0;
  logic [31:0]   stat_lit_cnt;
  logic [31:0]   stat_ref_cnt;
  logic [31:0]   stat_sym_cnt;
`endif

  tok_t       exp_q[$];
  tok_t       mdl_q[$];
  logic [7:0] stim_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         or_mode = 0;
  bit         hold = 1'b0;
  tok_t       hold_tok;

  always #5 clk = ~clk;

  lzss_stream_encoder #(
    .WORD_SIZE       (WS),
    .WINDOW_SIZE     (W),
    .LOOK_AHEAD_SIZE (L),
    .MIN_MATCH       (MM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef LZSS_STATS_EN
    .stat_clr     (stat_clr),
    .stat_lit_cnt (stat_lit_cnt),
    .stat_ref_cnt (stat_ref_cnt),
    .stat_sym_cnt (stat_sym_cnt),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Greedy LZSS over the whole stream: look-ahead = next min(L, remaining) symbols,
  // window = previous min(W, position) symbols of the same stream.
  task automatic model_run();
    int n, p, la, wc, bl, bd, l, c;
    tok_t t;
    mdl_q.delete();
    n = stim_q.size();
    p = 0;
    while (p < n) begin
      la = (n - p < L) ? n - p : L;
      wc = (p < W) ? p : W;
      bl = 0;
      bd = 0;
      for (int d = 1; d <= wc; d++) begin
        l = 0;
        while (l < la && l < d && stim_q[p+l] == stim_q[p-d+l]) l++;
        if (l > bl) begin
          bl = l;
          bd = d;
        end
      end
      if (bl >= MM) begin
        t.data = TW'(256 + (bd - 1) * 4 + (bl - MM));
        c = bl;
      end else begin
        t.data = TW'(stim_q[p]);
        c = 1;
      end
      t.last = (p + c == n);
      mdl_q.push_back(t);
      p += c;
    end
  endtask

  task automatic push_model();
    model_run();
    foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
  endtask

  task automatic drive_sym(input logic [7:0] d, input logic lst);
    int  guard;
    bit  hs;
    guard = 0;
    in_data  = d;
    in_last  = lst;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      guard++;
      if (guard > 2000) begin
        n_vec++;
        n_err++;
        $display("FAIL in_handshake_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drive_stream(input bit gaps);
    int n;
    n = stim_q.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      drive_sym(stim_q[i], i == n - 1);
    end
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (!(exp_q.size() == 0 && !busy)) begin
      @(negedge clk);
      cyc++;
      if (cyc > 5000) begin
        n_vec++;
        n_err++;
        $display("FAIL idle_timeout: %0d tokens pending, busy=%0b, required 0 pending", exp_q.size(), busy);
        exp_q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    int cyc;
    cyc = 0;
    while (!out_valid) begin
      @(negedge clk);
      cyc++;
      if (cyc > 1000) begin
        n_vec++;
        n_err++;
        $display("FAIL out_valid_timeout: out_valid=0 after %0d cycles, required 1", cyc);
        break;
      end
    end
  endtask

  task automatic load_short();
    stim_q = '{8'h41, 8'h42, 8'h41, 8'h42};
  endtask

  // out_ready pattern: 0 random, 1 held low, 2 held high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (or_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
      else              out_ready = (or_mode == 2);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) check("hold_stable", {out_valid, out_last, out_data}, {1'b1, hold_tok});
      if (out_valid) check("in_ready_during_emit", {31'b0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_token: got last=%0b data=%03h, required no token", out_last, out_data);
        end else begin
          check("token", {out_last, out_data}, exp_q.pop_front());
        end
      end
      hold     = out_valid && !out_ready;
      hold_tok = {out_last, out_data};
    end
  end

  initial begin
    int nl;
    #2;
    rst_n = 1'b0;
    #10;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    check("rst_out_data", {23'b0, out_data}, 32'd0);
`ifdef LZSS_STATS_EN
    check("rst_stat_sym", stat_sym_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", {31'b0, in_ready}, 32'd1);

    // Short stream, model pinned to hand-derived tokens.
    load_short();
    model_run();
    check("pin_short_count", mdl_q.size(), 32'd3);
    check("pin_short_t0", {23'b0, mdl_q[0]}, 32'h041);
    check("pin_short_t1", {23'b0, mdl_q[1]}, 32'h042);
    check("pin_short_t2", {23'b0, mdl_q[2]}, 32'h304);
    push_model();
    drive_stream(1'b0);
    wait_idle();
    check("short_idle_ready", {31'b0, in_ready}, 32'd1);
    check("short_idle_busy", {31'b0, busy}, 32'd0);

    // Same stream again: a stale window would turn the first 41 into a reference.
    load_short();
    push_model();
    drive_stream(1'b1);
    wait_idle();

    // Eight zeros.
    stim_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    model_run();
    check("pin_zero_count", mdl_q.size(), 32'd4);
    check("pin_zero_t0", {23'b0, mdl_q[0]}, 32'h000);
    check("pin_zero_t1", {23'b0, mdl_q[1]}, 32'h000);
    check("pin_zero_t2", {23'b0, mdl_q[2]}, 32'h104);
    check("pin_zero_t3", {23'b0, mdl_q[3]}, 32'h30E);
    push_model();
    drive_stream(1'b1);
    wait_idle();

    // Window limit: 00..27 then 00..03.
    stim_q.delete();
    for (int i = 0; i < 40; i++) stim_q.push_back(8'(i));
    for (int i = 0; i < 4; i++) stim_q.push_back(8'(i));
    model_run();
    nl = 0;
    foreach (mdl_q[i]) if (mdl_q[i].last) nl++;
    check("pin_win_count", mdl_q.size(), 32'd44);
    check("pin_win_t40", {23'b0, mdl_q[40]}, 32'h000);
    check("pin_win_t43", {23'b0, mdl_q[43]}, 32'h203);
    check("pin_win_lasts", nl, 32'd1);
    push_model();
    drive_stream(1'b1);
    wait_idle();

    // Backpressure: out_ready low for five cycles with a token waiting.
    or_mode = 1;
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom_range(0, 1)));
    push_model();
    fork
      drive_stream(1'b0);
      begin
        wait_out_valid();
        repeat (5) @(negedge clk);
        or_mode = 2;
      end
    join
    or_mode = 0;
    wait_idle();

    // Random streams sent back to back.
    for (int s = 0; s < 30; s++) begin
      int n, alpha;
      n     = (s % 5 == 4) ? $urandom_range(33, 45) : $urandom_range(1, 24);
      alpha = (s % 3 == 2) ? 255 : 2;
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom_range(0, alpha)));
      push_model();
      drive_stream(1'b1);
    end
    wait_idle();

    // Reset while a token waits in EMIT; nothing from it may appear afterwards.
    or_mode = 1;
    load_short();
    drive_stream(1'b0);
    wait_out_valid();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready_after_release", {31'b0, in_ready}, 32'd1);
    or_mode = 0;
    load_short();
    model_run();
    check("pin_replay_t2", {23'b0, mdl_q[2]}, 32'h304);
    push_model();
    drive_stream(1'b1);
    wait_idle();
`ifdef LZSS_STATS_EN
    check("stat_lit", stat_lit_cnt, 32'd2);
    check("stat_ref", stat_ref_cnt, 32'd1);
    check("stat_sym", stat_sym_cnt, 32'd4);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    check("stat_clr_sym", stat_sym_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
